// File: rtl/mult_share_pkg.sv
// rtl/mult_share_pkg.sv - shared types and default widths for the multiplier-sharing controller
package mult_share_pkg;

  localparam int N_REQ_DEF       = 4;
  localparam int DATA_W_DEF      = 8;
  localparam int TIMEOUT_CYC_DEF = 64;
  localparam int IDX_W           = $clog2(N_REQ_DEF);

  typedef enum logic [1:0] {IDLE, LAUNCH, SETTLE, BUSY} msc_state_e;

endpackage

// File: rtl/mult_share_ctrl_rr_arbiter.sv
// rtl/mult_share_ctrl_rr_arbiter.sv - combinational round-robin grant starting at a pointer
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic             gnt_valid_o,
  output logic [N_REQ-1:0] gnt_oh_o,
  output logic [IDX_W-1:0] gnt_idx_o
);

  // Scan from the pointer upward with wrap; the first pending request wins.
  always_comb begin
    logic [IDX_W-1:0] idx;
    gnt_valid_o = 1'b0;
    gnt_oh_o    = '0;
    gnt_idx_o   = '0;
    idx         = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = IDX_W'((int'(ptr_i) + k) % N_REQ);
      if (!gnt_valid_o && req_i[idx]) begin
        gnt_valid_o   = 1'b1;
        gnt_oh_o[idx] = 1'b1;
        gnt_idx_o     = idx;
      end
    end
  end

endmodule

// File: rtl/mult_share_ctrl.sv
// rtl/mult_share_ctrl.sv - shares one sequential multiplier among requesters; watchdog under MULT_TIMEOUT_EN
module mult_share_ctrl
  import mult_share_pkg::*;
#(
  parameter int N_REQ       = N_REQ_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_a,
  input  logic [N_REQ*DATA_W-1:0] req_b,
  output logic [N_REQ-1:0]        req_ack,
  output logic [N_REQ-1:0]        rsp_done,
  output logic [2*DATA_W-1:0]     rsp_product,
  output logic                    mult_start,
  output logic [DATA_W-1:0]       mult_multiplicand,
  output logic [DATA_W-1:0]       mult_multiplier,
  input  logic                    mult_ready,
  input  logic [2*DATA_W-1:0]     mult_product,
  output logic                    busy,
  output logic                    timeout_err
);

  localparam int OWN_W = (N_REQ == N_REQ_DEF) ? IDX_W : $clog2(N_REQ);

  msc_state_e          state_q, state_d;
  logic [OWN_W-1:0]    ptr_q, ptr_d;
  logic [OWN_W-1:0]    owner_q, owner_d;
  logic [DATA_W-1:0]   a_q, a_d, b_q, b_d;
  logic [N_REQ-1:0]    ack_q, ack_d, done_q, done_d;
  logic [2*DATA_W-1:0] rsp_q, rsp_d;

  logic                gnt_valid;
  logic [N_REQ-1:0]    gnt_oh;
  logic [OWN_W-1:0]    gnt_idx;
  logic                tmo_hit;

  rr_arbiter #(.N_REQ(N_REQ), .IDX_W(OWN_W)) u_arb (
    .req_i       (req_valid),
    .ptr_i       (ptr_q),
    .gnt_valid_o (gnt_valid),
    .gnt_oh_o    (gnt_oh),
    .gnt_idx_o   (gnt_idx)
  );

`ifdef MULT_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt_q;
  logic             tmo_q;

  // Watchdog fires on the cycle that would be the TIMEOUT_CYC-th spent in SETTLE+BUSY.
  assign tmo_hit = (state_q == BUSY) && !mult_ready && (32'(cnt_q) >= 32'(TIMEOUT_CYC - 1));

  // Cycle counter runs only while waiting on the multiplier; error flag is sticky.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      if (state_q == SETTLE || state_q == BUSY) cnt_q <= cnt_q + 1'b1;
      else                                      cnt_q <= '0;
      if (tmo_hit) tmo_q <= 1'b1;
    end
  end

  assign timeout_err = tmo_q;
`else
  assign tmo_hit     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // Next-state and datapath updates; ack/done default low so they are single-cycle pulses.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    a_d     = a_q;
    b_d     = b_q;
    ack_d   = '0;
    done_d  = '0;
    rsp_d   = rsp_q;
    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          a_d     = req_a[gnt_idx*DATA_W +: DATA_W];
          b_d     = req_b[gnt_idx*DATA_W +: DATA_W];
          ack_d   = gnt_oh;
          owner_d = gnt_idx;
          ptr_d   = (gnt_idx == OWN_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
          state_d = LAUNCH;
        end
      end
      LAUNCH: state_d = SETTLE;
      // The multiplier still shows the previous ready here, so it is not trusted yet.
      SETTLE: state_d = BUSY;
      BUSY: begin
        if (mult_ready) begin
          rsp_d           = mult_product;
          done_d[owner_q] = 1'b1;
          state_d         = IDLE;
        end else if (tmo_hit) begin
          rsp_d           = '0;
          done_d[owner_q] = 1'b1;
          state_d         = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any transaction without a response.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      ack_q   <= '0;
      done_q  <= '0;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
      rsp_q   <= rsp_d;
    end
  end

  assign req_ack           = ack_q;
  assign rsp_done          = done_q;
  assign rsp_product       = rsp_q;
  assign mult_start        = (state_q == LAUNCH);
  assign mult_multiplicand = a_q;
  assign mult_multiplier   = b_q;
  assign busy              = (state_q != IDLE);

endmodule

// File: tb/tb_mult_share_ctrl.sv
// tb/tb_mult_share_ctrl.sv - scoreboard bench for mult_share_ctrl with a sequential multiplier model
module tb_mult_share_ctrl;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int TO = 64;
  localparam int MLAT = 5;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_a = '0, req_b = '0;
  logic [N-1:0]   req_ack, rsp_done;
  logic [2*W-1:0] rsp_product;
  logic           mult_start;
  logic [W-1:0]   mult_multiplicand, mult_multiplier;
  logic           mult_ready;
  logic [2*W-1:0] mult_product;
  logic           busy, timeout_err;

  int errors = 0;
  int checks = 0;
  int starts = 0;
  int rem[N];
  logic [W-1:0] nxt_a[N], nxt_b[N];
  int exp_ack_q[$];
  int exp_idx_q[$];
  int exp_prod_q[$];
  logic stall = 1'b0;

  logic [W-1:0]   m_a, m_b;
  int             m_cnt;

  mult_share_ctrl #(.N_REQ(N), .DATA_W(W), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ack(req_ack), .rsp_done(rsp_done), .rsp_product(rsp_product),
    .mult_start(mult_start), .mult_multiplicand(mult_multiplicand),
    .mult_multiplier(mult_multiplier), .mult_ready(mult_ready),
    .mult_product(mult_product), .busy(busy), .timeout_err(timeout_err)
  );

  always #2 clk = ~clk;

  // Sequential multiplier: drops ready on start, returns a*b MLAT cycles later.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mult_ready   <= 1'b1;
      mult_product <= '0;
      m_cnt        <= 0;
      m_a          <= '0;
      m_b          <= '0;
    end else if (mult_start) begin
      mult_ready <= 1'b0;
      m_cnt      <= MLAT;
      m_a        <= mult_multiplicand;
      m_b        <= mult_multiplier;
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1 && !stall) begin
        mult_ready   <= 1'b1;
        mult_product <= 16'(m_a) * 16'(m_b);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic load(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    req_valid[i]    = 1'b1;
  endtask

  task automatic expect_txn(input int i, input int a, input int b);
    exp_ack_q.push_back(i);
    exp_idx_q.push_back(i);
    exp_prod_q.push_back(a * b);
  endtask

  // Requesters re-issue from nxt_* after each ack until rem runs out; DUT outputs are scored.
  task automatic run_sb(input int budget);
    int n = 0;
    int e;
    while ((exp_ack_q.size() != 0 || exp_idx_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
      if (mult_start) starts++;
      if (req_ack != '0) begin
        if (exp_ack_q.size() == 0) chk("ack_unexpected", 32'(req_ack), 0);
        else begin
          e = exp_ack_q.pop_front();
          chk("ack_idx", 32'(req_ack), 32'(1) << e);
        end
        for (int i = 0; i < N; i++) begin
          if (req_ack[i]) begin
            rem[i]--;
            if (rem[i] > 0) load(i, nxt_a[i], nxt_b[i]);
            else req_valid[i] = 1'b0;
          end
        end
      end
      if (rsp_done != '0) begin
        if (exp_idx_q.size() == 0) chk("done_unexpected", 32'(rsp_done), 0);
        else begin
          e = exp_idx_q.pop_front();
          chk("done_idx", 32'(rsp_done), 32'(1) << e);
          e = exp_prod_q.pop_front();
          chk("product", 32'(rsp_product), 32'(e));
        end
      end
    end
    if (n >= budget) chk("sb_budget_left", 32'(exp_ack_q.size() + exp_idx_q.size()), 0);
  endtask

  initial begin
    int s0;
    int n;
    for (int i = 0; i < N; i++) rem[i] = 0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ack", 32'(req_ack), 0);
    chk("rst_done", 32'(rsp_done), 0);
    chk("rst_start", 32'(mult_start), 0);
    chk("rst_ops", {16'd0, mult_multiplicand, mult_multiplier}, 0);
    chk("rst_prod", 32'(rsp_product), 0);
    chk("rst_tmo", 32'(timeout_err), 0);
    reset = 1'b1;
    @(negedge clk);

    // 1: req0 alone
    s0 = starts; rem[0] = 1; expect_txn(0, 8, 12); load(0, 8, 12);
    run_sb(100);
    chk("t1_starts", 32'(starts - s0), 1);

    // 2: req1 immediately after
    rem[1] = 1; expect_txn(1, 30, 4); load(1, 30, 4);
    run_sb(100);

    // req3 wraps the pointer back to 0
    rem[3] = 1; expect_txn(3, 6, 7); load(3, 6, 7);
    run_sb(100);

    // 3: req0 and req2 together with pointer 0
    s0 = starts;
    rem[0] = 1; rem[2] = 1;
    expect_txn(0, 3, 5); expect_txn(2, 7, 9);
    load(0, 3, 5); load(2, 7, 9);
    run_sb(200);
    chk("t3_starts", 32'(starts - s0), 2);
    repeat (3) @(negedge clk);
    chk("t3_prod_held", 32'(rsp_product), 63);

    // pointer is now 3; one req3 transaction brings it back to 0
    rem[3] = 1; expect_txn(3, 1, 1); load(3, 1, 1);
    run_sb(100);

    // 4: all four held valid, two transactions each
    s0 = starts;
    for (int i = 0; i < N; i++) begin
      rem[i]   = 2;
      nxt_a[i] = W'(200 - i);
      nxt_b[i] = W'(250 - 10 * i);
    end
    for (int i = 0; i < N; i++) expect_txn(i, i + 3, 2 * i + 5);
    for (int i = 0; i < N; i++) expect_txn(i, 200 - i, 250 - 10 * i);
    for (int i = 0; i < N; i++) load(i, W'(i + 3), W'(2 * i + 5));
    run_sb(400);
    chk("t4_starts", 32'(starts - s0), 8);

    // 5: reset during BUSY
    load(1, 100, 100);
    n = 0;
    while (!req_ack[1] && n < 20) begin @(negedge clk); n++; end
    chk("t5_ack", 32'(req_ack), 32'b0010);
    req_valid[1] = 1'b0;
    repeat (2) @(negedge clk);
    chk("t5_busy_before", 32'(busy), 1);
    reset = 1'b0;
    #1;
    chk("t5_busy", 32'(busy), 0);
    chk("t5_start", 32'(mult_start), 0);
    chk("t5_ops", {16'd0, mult_multiplicand, mult_multiplier}, 0);
    chk("t5_prod", 32'(rsp_product), 0);
    chk("t5_ack0", 32'(req_ack), 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t5_no_done_rst", 32'(rsp_done), 0);
    end
    reset = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("t5_no_done_after", 32'(rsp_done), 0);
    end
    rem[3] = 1; expect_txn(3, 255, 255); load(3, 255, 255);
    run_sb(100);

`ifdef MULT_TIMEOUT_EN
    // 6: multiplier never returns ready
    stall = 1'b1;
    load(2, 9, 9);
    n = 0;
    while (!req_ack[2] && n < 20) begin @(negedge clk); n++; end
    chk("t6_ack", 32'(req_ack), 32'b0100);
    req_valid[2] = 1'b0;
    n = 0;
    while (rsp_done == '0 && n < 4 * TO) begin @(negedge clk); n++; end
    chk("t6_latency", 32'(n), 32'(TO + 1));
    chk("t6_done", 32'(rsp_done), 32'b0100);
    chk("t6_prod", 32'(rsp_product), 0);
    chk("t6_tmo", 32'(timeout_err), 1);
    chk("t6_busy", 32'(busy), 0);
    stall = 1'b0;
    rem[0] = 1; expect_txn(0, 2, 2); load(0, 2, 2);
    run_sb(100);
    chk("t6_sticky", 32'(timeout_err), 1);
`else
    chk("no_tmo", 32'(timeout_err), 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
